// File: rtl/fb_arbiter.sv
// fb_arbiter: frame-buffer port controller and arbiter.
// Shares one single-port frame-buffer RAM between an internal clear engine,
// the rasterizer (writes) and the UART transmitter (reads), sequences each
// frame IDLE -> CLEAR -> DRAW -> DONE and measures the frame fill time.
// Optional feature macro: FB_CLEAR_EN (clear engine and CLEAR state present).
// Without it, start goes straight to DRAW and clear_color is unused.
module fb_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 65536,
    parameter int DATA_W = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] clear_color,
    input  logic              rast_req,
    input  logic [ADDR_W-1:0] rast_addr,
    input  logic [DATA_W-1:0] rast_wdata,
    output logic              rast_gnt,
    input  logic              rast_done,
    input  logic              tx_req,
    input  logic [ADDR_W-1:0] tx_addr,
    output logic              tx_gnt,
    output logic [DATA_W-1:0] tx_rdata,
    output logic              tx_rvalid,
    output logic              fb_we,
    output logic              fb_re,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [DATA_W-1:0] fb_wdata,
    input  logic [DATA_W-1:0] fb_rdata,
    output logic              done_drawing,
    output logic [23:0]       fill_time,
    output logic              busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CLEAR = 2'd1;
    localparam logic [1:0] S_DRAW  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // Round-robin memory: who got the port on the last DRAW grant.
    localparam logic LW_RAST = 1'b0;
    localparam logic LW_TX   = 1'b1;

    localparam logic [23:0] FILL_MAX = 24'hFFFFFF;

    logic [1:0]  state_reg, state_next;
    logic        last_winner_reg;
    logic [23:0] fill_reg;
    logic        rvalid_reg;

`ifdef FB_CLEAR_EN
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    logic [ADDR_W-1:0] clr_cnt_reg, clr_cnt_next;
`else
    // Clear engine absent: these inputs/parameters intentionally go nowhere.
    localparam int UNUSED_DEPTH = DEPTH;
    logic unused_clear_color;
    assign unused_clear_color = ^clear_color;
`endif

    assign busy         = (state_reg == S_CLEAR) || (state_reg == S_DRAW);
    assign done_drawing = (state_reg == S_DONE);
    assign fill_time    = fill_reg;
    assign tx_rvalid    = rvalid_reg;
    // Gated so the read data bus is quiet whenever no read is returning.
    assign tx_rdata     = rvalid_reg ? fb_rdata : '0;

    // Grants: round-robin on conflict in DRAW, transmitter-only in DONE.
    always_comb begin
        rast_gnt = 1'b0;
        tx_gnt   = 1'b0;
        case (state_reg)
            S_DRAW: begin
                if (rast_req && tx_req) begin
                    rast_gnt = (last_winner_reg == LW_TX);
                    tx_gnt   = (last_winner_reg == LW_RAST);
                end else begin
                    rast_gnt = rast_req;
                    tx_gnt   = tx_req;
                end
            end
            S_DONE:  tx_gnt = tx_req;
            default: ;
        endcase
    end

    // RAM port mux: clear engine, then the granted requester.
    always_comb begin
        fb_we    = 1'b0;
        fb_re    = 1'b0;
        fb_addr  = '0;
        fb_wdata = '0;
`ifdef FB_CLEAR_EN
        if (state_reg == S_CLEAR) begin
            fb_we    = 1'b1;
            fb_addr  = clr_cnt_reg;
            fb_wdata = clear_color;
        end
`endif
        if (rast_gnt) begin
            fb_we    = 1'b1;
            fb_addr  = rast_addr;
            fb_wdata = rast_wdata;
        end else if (tx_gnt) begin
            fb_re   = 1'b1;
            fb_addr = tx_addr;
        end
    end

    // Frame sequencer next state; start overrides everything, including rast_done.
    always_comb begin
        state_next = state_reg;
        if (start) begin
`ifdef FB_CLEAR_EN
            state_next = S_CLEAR;
`else
            state_next = S_DRAW;
`endif
        end else begin
            case (state_reg)
`ifdef FB_CLEAR_EN
                S_CLEAR: if (clr_cnt_reg == LAST_ADDR) state_next = S_DRAW;
`endif
                S_DRAW:  if (rast_done) state_next = S_DONE;
                default: ;
            endcase
        end
    end

`ifdef FB_CLEAR_EN
    // Clear address: restarts at 0 on start, steps one pixel per CLEAR cycle.
    always_comb begin
        clr_cnt_next = clr_cnt_reg;
        if (start || (state_reg == S_CLEAR && clr_cnt_reg == LAST_ADDR))
            clr_cnt_next = '0;
        else if (state_reg == S_CLEAR)
            clr_cnt_next = clr_cnt_reg + 1'b1;
    end

    // Clear address register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) clr_cnt_reg <= '0;
        else        clr_cnt_reg <= clr_cnt_next;
    end
`endif

    // State, round-robin pointer, fill-time counter and read-valid pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= S_IDLE;
            last_winner_reg <= LW_TX;
            fill_reg        <= '0;
            rvalid_reg      <= 1'b0;
        end else begin
            state_reg  <= state_next;
            rvalid_reg <= tx_req && tx_gnt;
            if (state_reg == S_DRAW) begin
                if (rast_gnt)    last_winner_reg <= LW_RAST;
                else if (tx_gnt) last_winner_reg <= LW_TX;
            end
            if (start)
                fill_reg <= '0;
            else if (busy && fill_reg != FILL_MAX)
                fill_reg <= fill_reg + 24'd1;
        end
    end

endmodule

// File: tb/tb_fb_arbiter.sv
// tb_fb_arbiter: scoreboard bench for fb_arbiter (DEPTH=16).
// Expected read data is pushed when a read is granted and popped on tx_rvalid.
// Expectations follow FB_CLEAR_EN so the bench works in either build.
module tb_fb_arbiter;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 16;
    localparam int DATA_W = 24;
`ifdef FB_CLEAR_EN
    localparam int CLR_CYC = DEPTH;
`else
    localparam int CLR_CYC = 0;
`endif

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [DATA_W-1:0] clear_color;
    logic              rast_req;
    logic [ADDR_W-1:0] rast_addr;
    logic [DATA_W-1:0] rast_wdata;
    logic              rast_gnt;
    logic              rast_done;
    logic              tx_req;
    logic [ADDR_W-1:0] tx_addr;
    logic              tx_gnt;
    logic [DATA_W-1:0] tx_rdata;
    logic              tx_rvalid;
    logic              fb_we;
    logic              fb_re;
    logic [ADDR_W-1:0] fb_addr;
    logic [DATA_W-1:0] fb_wdata;
    logic [DATA_W-1:0] fb_rdata;
    logic              done_drawing;
    logic [23:0]       fill_time;
    logic              busy;

    int n_vec = 0;
    int n_err = 0;

    logic [DATA_W-1:0] ram [256];
    logic [DATA_W-1:0] ref_mem [256];
    logic [DATA_W-1:0] sb [$];
    logic [DATA_W-1:0] sb_exp;

    fb_arbiter #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .clear_color(clear_color),
        .rast_req(rast_req), .rast_addr(rast_addr), .rast_wdata(rast_wdata),
        .rast_gnt(rast_gnt), .rast_done(rast_done),
        .tx_req(tx_req), .tx_addr(tx_addr), .tx_gnt(tx_gnt),
        .tx_rdata(tx_rdata), .tx_rvalid(tx_rvalid),
        .fb_we(fb_we), .fb_re(fb_re), .fb_addr(fb_addr), .fb_wdata(fb_wdata),
        .fb_rdata(fb_rdata), .done_drawing(done_drawing),
        .fill_time(fill_time), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port RAM with one-cycle registered read.
    always @(posedge clk) begin
        if (fb_we) ram[fb_addr] <= fb_wdata;
        if (fb_re) fb_rdata <= ram[fb_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one cycle; pulse inputs drop automatically.
    task automatic tick();
        @(posedge clk);
        #1;
        start     = 1'b0;
        rast_done = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_fill"},   32'(fill_time), 0);
        chk({tag, "_done"},   32'(done_drawing), 0);
        chk({tag, "_busy"},   32'(busy), 0);
        chk({tag, "_rvalid"}, 32'(tx_rvalid), 0);
        chk({tag, "_rdata"},  32'(tx_rdata), 0);
        chk({tag, "_rgnt"},   32'(rast_gnt), 0);
        chk({tag, "_tgnt"},   32'(tx_gnt), 0);
        chk({tag, "_we"},     32'(fb_we), 0);
        chk({tag, "_re"},     32'(fb_re), 0);
        chk({tag, "_addr"},   32'(fb_addr), 0);
        chk({tag, "_wdata"},  32'(fb_wdata), 0);
    endtask

    // Scoreboard: pop on returned read, push on granted read.
    always @(negedge clk) begin
        if (tx_rvalid) begin
            if (sb.size() == 0) begin
                chk("rvalid_spurious", 32'(sb.size()), 1);
            end else begin
                sb_exp = sb.pop_front();
                chk("rdata", 32'(tx_rdata), 32'(sb_exp));
                $display("txn read data=%h expected=%h", tx_rdata, sb_exp);
            end
        end
        if (rst_n && tx_req && tx_gnt) sb.push_back(ref_mem[tx_addr]);
    end

    initial begin
        int  ri;
        int  ti;
        logic exp_r;
        logic [7:0] dn_addr [3];
        dn_addr = '{8'd0, 8'd1, 8'd4};
        ri = 0;
        ti = 0;
        rst_n = 1'b0; start = 1'b0; clear_color = '0; rast_done = 1'b0;
        rast_req = 1'b1; rast_addr = '0; rast_wdata = '0;
        tx_req = 1'b1; tx_addr = '0;

        // Reset state.
        repeat (2) @(posedge clk);
        #3;
        chk_all_zero("reset");
        rst_n = 1'b1;

        // IDLE: requests are not granted.
        tick(); #2;
        chk("idle_rgnt", 32'(rast_gnt), 0);
        chk("idle_tgnt", 32'(tx_gnt), 0);
        $display("txn idle requests ignored");

        // Start a frame with rast_req held high.
        tx_req = 1'b0;
        clear_color = 24'hABCDEF;
        start = 1'b1;
        for (int i = 0; i < CLR_CYC; i++) begin
            tick(); #2;
            chk("sweep_we",    32'(fb_we), 1);
            chk("sweep_addr",  32'(fb_addr), 32'(i));
            chk("sweep_data",  32'(fb_wdata), 32'h00ABCDEF);
            chk("sweep_rgnt",  32'(rast_gnt), 0);
            chk("sweep_busy",  32'(busy), 1);
            if (i == 0) chk("sweep_fill0", 32'(fill_time), 0);
            $display("txn clear addr=%0d data=%h", fb_addr, fb_wdata);
        end

        // DRAW: 8 conflict cycles, one lone rast, one lone tx with rast_done.
        for (int k = 0; k < 10; k++) begin
            tick();
            rast_req   = (k != 9);
            tx_req     = (k != 8);
            rast_addr  = 8'(ri);
            rast_wdata = 24'h123400 + 24'(ri * 7);
            tx_addr    = 8'(ti);
            rast_done  = (k == 9);
            #2;
            exp_r = (k < 8) ? (k % 2 == 0) : (k == 8);
            chk("rr_rgnt", 32'(rast_gnt), 32'(exp_r));
            chk("rr_tgnt", 32'(tx_gnt), 32'(!exp_r));
            chk("rr_busy", 32'(busy), 1);
            if (exp_r) begin
                chk("rr_we",    32'(fb_we), 1);
                chk("rr_waddr", 32'(fb_addr), 32'(ri));
                chk("rr_wdata", 32'(fb_wdata), 32'(rast_wdata));
            end else begin
                chk("rr_re",    32'(fb_re), 1);
                chk("rr_raddr", 32'(fb_addr), 32'(ti));
            end
            $display("txn draw cycle=%0d rast_gnt=%0b tx_gnt=%0b", k + 1, rast_gnt, tx_gnt);
            if (rast_gnt) begin
                ref_mem[8'(ri)] = rast_wdata;
                ri++;
            end
            if (tx_gnt) ti++;
        end

        // DONE: tx granted every cycle, rasterizer locked out.
        for (int j = 0; j < 3; j++) begin
            tick();
            rast_req = 1'b1;
            tx_req   = 1'b1;
            tx_addr  = dn_addr[j];
            #2;
            if (j == 0) begin
                chk("done_flag", 32'(done_drawing), 1);
                chk("done_fill", 32'(fill_time), 32'(CLR_CYC + 10));
                chk("done_busy", 32'(busy), 0);
            end
            chk("done_tgnt", 32'(tx_gnt), 1);
            chk("done_re",   32'(fb_re), 1);
            chk("done_rgnt", 32'(rast_gnt), 0);
            $display("txn done read addr=%0d fill=%0d", tx_addr, fill_time);
        end
        tick();
        rast_req = 1'b0;
        tx_req   = 1'b0;
        start    = 1'b1;

        // New frame, then restart in the 5th DRAW cycle.
        for (int i = 0; i < CLR_CYC; i++) tick();
        for (int d = 1; d <= 5; d++) begin
            tick();
            if (d == 5) start = 1'b1;
            #2;
            chk("rs_drawbusy", 32'(busy), 1);
        end
        tick(); #2;
        chk("rs_fill0", 32'(fill_time), 0);
        chk("rs_done0", 32'(done_drawing), 0);
`ifdef FB_CLEAR_EN
        chk("rs_we",   32'(fb_we), 1);
        chk("rs_addr", 32'(fb_addr), 0);
`else
        chk("rs_noclr", 32'(fb_we), 0);
`endif
        tick(); #2;
        chk("rs_fill1", 32'(fill_time), 1);
        chk("rs_done1", 32'(done_drawing), 0);
        $display("txn restart fill=%0d", fill_time);
        for (int i = 2; i < CLR_CYC; i++) tick();

        // Reset mid-DRAW while a read is granted.
        tick();
        tx_req  = 1'b1;
        tx_addr = 8'd3;
        #2;
        chk("rst_pre_tgnt", 32'(tx_gnt), 1);
        #3;
        rst_n = 1'b0;
        #1;
        chk_all_zero("rst_mid");
        tick();
        chk("rst_hold_rvalid", 32'(tx_rvalid), 0);
        rst_n = 1'b1;
        tick(); #2;
        chk("rst_post_rvalid", 32'(tx_rvalid), 0);
        chk("rst_post_busy",   32'(busy), 0);
        chk("rst_post_tgnt",   32'(tx_gnt), 0);
        $display("txn reset mid-frame");
        tx_req = 1'b0;
        sb.delete();
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
